// File: rtl/uart_csr_pkg.sv
// Shared definitions for the UART CSR block: register offsets, bit positions
// inside STAT/CTRL/DEBUG, datapath widths and the reset divisor calculation.
package uart_csr_pkg;

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CSR_W  = 32;

  // Register offsets, decoded from csr_a[2:0]
  localparam logic [2:0] REG_RXTX    = 3'd0;
  localparam logic [2:0] REG_DIVISOR = 3'd1;
  localparam logic [2:0] REG_STAT    = 3'd2;
  localparam logic [2:0] REG_CTRL    = 3'd3;
  localparam logic [2:0] REG_DEBUG   = 3'd4;

  // STAT bits
  localparam int unsigned STAT_THRE   = 0;
  localparam int unsigned STAT_RX_EVT = 1;
  localparam int unsigned STAT_TX_EVT = 2;

  // CTRL bits
  localparam int unsigned CTRL_RX_INT = 0;
  localparam int unsigned CTRL_TX_INT = 1;
  localparam int unsigned CTRL_THRU   = 2;

  // DEBUG bits
  localparam int unsigned DEBUG_BREAK_EN = 0;

  // Reset divisor: sys_clk cycles per 16x oversampling tick, truncated
  function automatic logic [DIV_W-1:0] default_divisor(input int unsigned clk_hz,
                                                       input int unsigned baud_bps);
    return DIV_W'(clk_hz / (32'd16 * baud_bps));
  endfunction

endpackage

// File: rtl/uart_csr_transceiver.sv
// uart_transceiver: 16x baud tick generator plus 8N1 receiver and transmitter.
// Ports:
//   sys_clk, sys_rst   clock and synchronous active-high reset
//   divisor            sys_clk cycles per oversampling tick
//   break_en           report all-zero frames with a low stop bit as a break
//   rx                 asynchronous serial input
//   rx_sync            rx after the two-flop synchronizer
//   rx_data/rx_done    received byte and one-cycle valid-frame pulse
//   rx_break           one-cycle line-break pulse
//   tx_start/tx_data   start a transmission of tx_data (only honoured when idle)
//   tx_line            serial output (idle high)
//   tx_done            one-cycle pulse at the end of the stop bit
module uart_transceiver
  import uart_csr_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DIV_W-1:0]  divisor,
  input  logic              break_en,
  input  logic              rx,
  output logic              rx_sync,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_done,
  output logic              rx_break,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_line,
  output logic              tx_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [3:0] MID_TICK  = 4'd7;
  localparam logic [3:0] LAST_TICK = 4'd15;
  localparam logic [2:0] LAST_BIT  = 3'd7;

  // Two-flop synchronizer for the asynchronous input
  logic rx_meta;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Oversampling tick; the >= compare tolerates a divisor lowered mid-count
  logic [DIV_W-1:0] tick_cnt;
  logic             tick_c;
  assign tick_c = ({1'b0, tick_cnt} + (DIV_W+1)'(1)) >= {1'b0, divisor};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) tick_cnt <= '0;
    else if (tick_c) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + DIV_W'(1);
  end

  // ---------------------------------------------------------------- receiver
  logic [1:0]        rx_state, rx_state_nxt;
  logic [3:0]        rx_cnt, rx_cnt_nxt;
  logic [2:0]        rx_bits, rx_bits_nxt;
  logic [DATA_W-1:0] rx_shift, rx_shift_nxt;
  logic [DATA_W-1:0] rx_data_nxt;
  logic              rx_done_nxt, rx_break_nxt;
  logic              rx_wait_high, rx_wait_high_nxt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_state     <= ST_IDLE;
      rx_cnt       <= '0;
      rx_bits      <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_done      <= 1'b0;
      rx_break     <= 1'b0;
      rx_wait_high <= 1'b0;
    end else begin
      rx_state     <= rx_state_nxt;
      rx_cnt       <= rx_cnt_nxt;
      rx_bits      <= rx_bits_nxt;
      rx_shift     <= rx_shift_nxt;
      rx_data      <= rx_data_nxt;
      rx_done      <= rx_done_nxt;
      rx_break     <= rx_break_nxt;
      rx_wait_high <= rx_wait_high_nxt;
    end
  end

  // RX next state: start validated at mid-bit, data/stop sampled every 16 ticks
  always_comb begin
    rx_state_nxt     = rx_state;
    rx_cnt_nxt       = rx_cnt;
    rx_bits_nxt      = rx_bits;
    rx_shift_nxt     = rx_shift;
    rx_data_nxt      = rx_data;
    rx_done_nxt      = 1'b0;
    rx_break_nxt     = 1'b0;
    rx_wait_high_nxt = rx_wait_high;

    // After a framing error no start bit is accepted until the line idles high
    if (rx_wait_high && rx_sync) rx_wait_high_nxt = 1'b0;

    case (rx_state)
      ST_IDLE: begin
        if (tick_c && !rx_sync && !rx_wait_high) begin
          rx_state_nxt = ST_START;
          rx_cnt_nxt   = '0;
        end
      end
      ST_START: begin
        if (tick_c) begin
          if (rx_cnt == MID_TICK) begin
            rx_cnt_nxt  = '0;
            rx_bits_nxt = '0;
            // A start bit that is high again at mid-bit was a glitch
            rx_state_nxt = rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt_nxt = rx_cnt + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          if (rx_cnt == LAST_TICK) begin
            rx_cnt_nxt   = '0;
            rx_shift_nxt = {rx_sync, rx_shift[DATA_W-1:1]};
            rx_bits_nxt  = rx_bits + 3'd1;
            if (rx_bits == LAST_BIT) rx_state_nxt = ST_STOP;
          end else begin
            rx_cnt_nxt = rx_cnt + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick_c) begin
          if (rx_cnt == LAST_TICK) begin
            rx_cnt_nxt   = '0;
            rx_state_nxt = ST_IDLE;
            if (rx_sync) begin
              rx_data_nxt = rx_shift;
              rx_done_nxt = 1'b1;
            end else begin
              rx_wait_high_nxt = 1'b1;
              rx_break_nxt     = break_en && (rx_shift == '0);
            end
          end else begin
            rx_cnt_nxt = rx_cnt + 4'd1;
          end
        end
      end
      default: rx_state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------- transmitter
  logic [1:0]        tx_state, tx_state_nxt;
  logic [3:0]        tx_cnt, tx_cnt_nxt;
  logic [2:0]        tx_bits, tx_bits_nxt;
  logic [DATA_W-1:0] tx_shift, tx_shift_nxt;
  logic              tx_line_nxt, tx_done_nxt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bits  <= tx_bits_nxt;
      tx_shift <= tx_shift_nxt;
      tx_line  <= tx_line_nxt;
      tx_done  <= tx_done_nxt;
    end
  end

  // TX next state: each bit lasts 16 ticks, LSB first
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bits_nxt  = tx_bits;
    tx_shift_nxt = tx_shift;
    tx_line_nxt  = tx_line;
    tx_done_nxt  = 1'b0;

    case (tx_state)
      ST_IDLE: begin
        tx_line_nxt = 1'b1;
        if (tx_start) begin
          tx_shift_nxt = tx_data;
          tx_line_nxt  = 1'b0;
          tx_cnt_nxt   = '0;
          tx_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (tick_c) begin
          if (tx_cnt == LAST_TICK) begin
            tx_cnt_nxt   = '0;
            tx_bits_nxt  = '0;
            tx_line_nxt  = tx_shift[0];
            tx_shift_nxt = {1'b0, tx_shift[DATA_W-1:1]};
            tx_state_nxt = ST_DATA;
          end else begin
            tx_cnt_nxt = tx_cnt + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          if (tx_cnt == LAST_TICK) begin
            tx_cnt_nxt = '0;
            if (tx_bits == LAST_BIT) begin
              tx_line_nxt  = 1'b1;
              tx_state_nxt = ST_STOP;
            end else begin
              tx_line_nxt  = tx_shift[0];
              tx_shift_nxt = {1'b0, tx_shift[DATA_W-1:1]};
              tx_bits_nxt  = tx_bits + 3'd1;
            end
          end else begin
            tx_cnt_nxt = tx_cnt + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick_c) begin
          if (tx_cnt == LAST_TICK) begin
            tx_cnt_nxt   = '0;
            tx_done_nxt  = 1'b1;
            tx_state_nxt = ST_IDLE;
          end else begin
            tx_cnt_nxt = tx_cnt + 4'd1;
          end
        end
      end
      default: tx_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_csr.sv
// uart_csr: CSR-mapped 8N1 UART with interrupt, loop-through and break detect.
// Ports:
//   sys_clk, sys_rst   clock and synchronous active-high reset
//   csr_a              [13:10] bank select, [2:0] register offset
//   csr_we, csr_di     single-cycle write strobe and write data
//   csr_do             registered read data (0 when the bank is not selected)
//   irq                registered level interrupt
//   uart_rx, uart_tx   serial input / output, both idle high
//   rx_break           one-cycle pulse on a detected line break
module uart_csr
  import uart_csr_pkg::*;
#(
  parameter logic [3:0]  csr_addr         = 4'h0,
  parameter int unsigned clk_freq         = 100000000,
  parameter int unsigned baud             = 115200,
  parameter logic        break_en_default = 1'b0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [13:0]      csr_a,
  input  logic             csr_we,
  input  logic [CSR_W-1:0] csr_di,
  output logic [CSR_W-1:0] csr_do,
  output logic             irq,
  input  logic             uart_rx,
  output logic             uart_tx,
  output logic             rx_break
);

  localparam logic [DIV_W-1:0] DIV_RESET = default_divisor(clk_freq, baud);

  logic [DIV_W-1:0]  divisor, divisor_nxt;
  logic              thre, thre_nxt;
  logic              rx_evt, rx_evt_nxt;
  logic              tx_evt, tx_evt_nxt;
  logic              rx_int, rx_int_nxt;
  logic              tx_int, tx_int_nxt;
  logic              thru, thru_nxt;
  logic              break_en, break_en_nxt;
  logic              irq_nxt;

  logic              rx_sync, rx_done, tx_line, tx_done;
  logic [DATA_W-1:0] rx_data;

  // Address decode
  logic       bank_sel_c, wr_c, tx_start_c;
  logic [2:0] reg_idx_c;
  assign bank_sel_c = (csr_a[13:10] == csr_addr);
  assign reg_idx_c  = csr_a[2:0];
  assign wr_c       = csr_we && bank_sel_c;
  // A write to RXTX while the transmitter holds a byte is dropped
  assign tx_start_c = wr_c && (reg_idx_c == REG_RXTX) && thre;

  logic unused_c;
  assign unused_c = ^{csr_a[9:3], csr_di[CSR_W-1:DIV_W]};

  uart_transceiver u_xcvr (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .divisor  (divisor),
    .break_en (break_en),
    .rx       (uart_rx),
    .rx_sync  (rx_sync),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_break (rx_break),
    .tx_start (tx_start_c),
    .tx_data  (csr_di[DATA_W-1:0]),
    .tx_line  (tx_line),
    .tx_done  (tx_done)
  );

  // Register updates; hardware event sets are applied last so they win over clears
  always_comb begin
    divisor_nxt  = divisor;
    thre_nxt     = thre;
    rx_evt_nxt   = rx_evt;
    tx_evt_nxt   = tx_evt;
    rx_int_nxt   = rx_int;
    tx_int_nxt   = tx_int;
    thru_nxt     = thru;
    break_en_nxt = break_en;

    if (wr_c) begin
      case (reg_idx_c)
        REG_DIVISOR: divisor_nxt = csr_di[DIV_W-1:0];
        REG_STAT: begin
          if (csr_di[STAT_RX_EVT]) rx_evt_nxt = 1'b0;
          if (csr_di[STAT_TX_EVT]) tx_evt_nxt = 1'b0;
        end
        REG_CTRL: begin
          rx_int_nxt = csr_di[CTRL_RX_INT];
          tx_int_nxt = csr_di[CTRL_TX_INT];
          thru_nxt   = csr_di[CTRL_THRU];
        end
        REG_DEBUG: break_en_nxt = csr_di[DEBUG_BREAK_EN];
        default: ;
      endcase
    end

    if (tx_start_c) thre_nxt = 1'b0;
    if (tx_done) begin
      thre_nxt   = 1'b1;
      tx_evt_nxt = 1'b1;
    end
    if (rx_done) rx_evt_nxt = 1'b1;

    // Built from next values so irq tracks STAT/CTRL writes one cycle later
    irq_nxt = (rx_evt_nxt && rx_int_nxt) || (tx_evt_nxt && tx_int_nxt);
  end

  // Read mux
  logic [CSR_W-1:0] rd_data_c;
  always_comb begin
    rd_data_c = '0;
    case (reg_idx_c)
      REG_RXTX:    rd_data_c[DATA_W-1:0] = rx_data;
      REG_DIVISOR: rd_data_c[DIV_W-1:0]  = divisor;
      REG_STAT: begin
        rd_data_c[STAT_THRE]   = thre;
        rd_data_c[STAT_RX_EVT] = rx_evt;
        rd_data_c[STAT_TX_EVT] = tx_evt;
      end
      REG_CTRL: begin
        rd_data_c[CTRL_RX_INT] = rx_int;
        rd_data_c[CTRL_TX_INT] = tx_int;
        rd_data_c[CTRL_THRU]   = thru;
      end
      REG_DEBUG: rd_data_c[DEBUG_BREAK_EN] = break_en;
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      divisor  <= DIV_RESET;
      thre     <= 1'b1;
      rx_evt   <= 1'b0;
      tx_evt   <= 1'b0;
      rx_int   <= 1'b0;
      tx_int   <= 1'b0;
      thru     <= 1'b0;
      break_en <= break_en_default;
      irq      <= 1'b0;
      csr_do   <= '0;
      uart_tx  <= 1'b1;
    end else begin
      divisor  <= divisor_nxt;
      thre     <= thre_nxt;
      rx_evt   <= rx_evt_nxt;
      tx_evt   <= tx_evt_nxt;
      rx_int   <= rx_int_nxt;
      tx_int   <= tx_int_nxt;
      thru     <= thru_nxt;
      break_en <= break_en_nxt;
      irq      <= irq_nxt;
      csr_do   <= bank_sel_c ? rd_data_c : '0;
      // Loop-through mirrors the synchronized input; the transmitter still runs
      uart_tx  <= thru ? rx_sync : tx_line;
    end
  end

endmodule

// File: tb/tb_uart_csr.sv
// Directed self-checking bench for uart_csr (80 MHz, 115200 baud => divisor 43).
module tb_uart_csr;
  import uart_csr_pkg::*;

  localparam logic [3:0] BANK   = 4'h2;
  localparam int         BIT43  = 16 * 43;
  localparam int         BIT4   = 16 * 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        irq, uart_rx, uart_tx, rx_break;
  logic        rx_drv, loop_en;

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  always #5 sys_clk = ~sys_clk;

  uart_csr #(
    .csr_addr         (BANK),
    .clk_freq         (80000000),
    .baud             (115200),
    .break_en_default (1'b0)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .csr_a    (csr_a),
    .csr_we   (csr_we),
    .csr_di   (csr_di),
    .csr_do   (csr_do),
    .irq      (irq),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .rx_break (rx_break)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;
  int   brk_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are observed 1 time unit after the rising edge
  task automatic cyc();
    @(posedge sys_clk);
    #1;
    if (rx_break === 1'b1) brk_cnt++;
  endtask

  task automatic wait_n(input int n);
    repeat (n) cyc();
  endtask

  task automatic csr_wr_bank(input logic [3:0] bank, input logic [2:0] idx, input logic [31:0] d);
    csr_a  = {bank, 7'd0, idx};
    csr_di = d;
    csr_we = 1'b1;
    cyc();
    csr_we = 1'b0;
  endtask

  task automatic csr_wr(input logic [2:0] idx, input logic [31:0] d);
    csr_wr_bank(BANK, idx, d);
  endtask

  task automatic csr_rd_bank(input logic [3:0] bank, input logic [2:0] idx,
                             input logic [31:0] exp, input string tag);
    exp_t e;
    e.tag = tag;
    e.val = exp;
    sb_q.push_back(e);
    csr_a  = {bank, 7'd0, idx};
    csr_we = 1'b0;
    cyc();
    e = sb_q.pop_front();
    check(e.tag, csr_do, e.val);
  endtask

  task automatic csr_rd(input logic [2:0] idx, input logic [31:0] exp, input string tag);
    csr_rd_bank(BANK, idx, exp, tag);
  endtask

  task automatic send_byte(input logic [7:0] b, input int bitc);
    rx_drv = 1'b0;
    wait_n(bitc);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      wait_n(bitc);
    end
    rx_drv = 1'b1;
    wait_n(bitc);
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cnt;
    int          lat;
    logic        done;
    logic        extra;
    logic [7:0]  line_b;
    exp_t        e;

    n_cmp   = 0;
    n_bad   = 0;
    brk_cnt = 0;
    sys_rst = 1'b1;
    csr_a   = '0;
    csr_we  = 1'b0;
    csr_di  = '0;
    rx_drv  = 1'b1;
    loop_en = 1'b0;

    // Reset state
    wait_n(3);
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_break", 32'(rx_break), 32'd0);
    check("rst_csr_do", csr_do, 32'd0);
    sys_rst = 1'b0;
    cyc();

    csr_rd(REG_DIVISOR, 32'd43, "divisor_default");
    csr_rd(REG_STAT, 32'h1, "stat_after_reset");
    csr_rd(REG_CTRL, 32'h0, "ctrl_after_reset");
    csr_rd(REG_DEBUG, 32'h0, "debug_after_reset");
    csr_rd_bank(4'h1, REG_DIVISOR, 32'h0, "other_bank_reads_zero");
    csr_wr_bank(4'h1, REG_DIVISOR, 32'd7);
    csr_rd(REG_DIVISOR, 32'd43, "other_bank_write_ignored");
    csr_wr(3'd5, 32'hFFFF_FFFF);
    csr_rd(3'd5, 32'h0, "unmapped_offset_zero");

    // Loopback transfer at the default divisor
    loop_en = 1'b1;
    wait_n(2);
    csr_wr(REG_RXTX, 32'h55);
    csr_rd(REG_STAT, 32'h0, "stat_busy_after_write");
    cnt  = 1;
    done = 1'b0;
    csr_a = {BANK, 7'd0, REG_STAT};
    while (!done && cnt < 8000) begin
      cyc();
      cnt++;
      done = csr_do[STAT_THRE];
    end
    check("thre_returns", 32'(done), 32'd1);
    check("frame_about_10_bits", 32'(cnt >= 6700 && cnt <= 7000), 32'd1);
    csr_rd(REG_STAT, 32'h7, "stat_after_loopback");
    csr_rd(REG_RXTX, 32'h55, "rxtx_loopback_byte");

    // Interrupt enable and event clear
    check("irq_masked", 32'(irq), 32'd0);
    csr_wr(REG_CTRL, 32'h3);
    check("irq_enabled_pending", 32'(irq), 32'd1);
    csr_wr(REG_STAT, 32'h6);
    check("irq_after_clear", 32'(irq), 32'd0);
    csr_rd(REG_STAT, 32'h1, "stat_after_clear");
    csr_wr(REG_CTRL, 32'h0);
    loop_en = 1'b0;

    // Loop-through latency
    csr_wr(REG_CTRL, 32'h4);
    wait_n(5);
    rx_drv = 1'b0;
    lat = 0;
    while (uart_tx !== 1'b0 && lat < 10) begin
      cyc();
      lat++;
    end
    check("thru_fall_latency", 32'(lat >= 2 && lat <= 3), 32'd1);
    rx_drv = 1'b1;
    lat = 0;
    while (uart_tx !== 1'b1 && lat < 10) begin
      cyc();
      lat++;
    end
    check("thru_rise_latency", 32'(lat >= 2 && lat <= 3), 32'd1);
    csr_wr(REG_CTRL, 32'h0);
    wait_n(500);

    // Line break with BREAK_EN=1
    csr_wr(REG_DEBUG, 32'h1);
    csr_rd(REG_DEBUG, 32'h1, "debug_break_en_set");
    brk_cnt = 0;
    rx_drv  = 1'b0;
    wait_n(12 * BIT43);
    rx_drv  = 1'b1;
    wait_n(2 * BIT43);
    check("break_pulse_count", 32'(brk_cnt), 32'd1);
    csr_rd(REG_STAT, 32'h1, "no_rx_evt_on_break");

    // Faster divisor; break disabled discards the frame, then a clean frame
    csr_wr(REG_DIVISOR, 32'd4);
    csr_rd(REG_DIVISOR, 32'd4, "divisor_written");
    csr_wr(REG_DEBUG, 32'h0);
    brk_cnt = 0;
    rx_drv  = 1'b0;
    wait_n(12 * BIT4);
    rx_drv  = 1'b1;
    wait_n(2 * BIT4);
    check("no_break_when_disabled", 32'(brk_cnt), 32'd0);
    csr_rd(REG_STAT, 32'h1, "discarded_frame_no_evt");
    send_byte(8'hA3, BIT4);
    csr_rd(REG_STAT, 32'h3, "stat_after_rx_frame");
    csr_rd(REG_RXTX, 32'hA3, "rxtx_external_byte");
    csr_wr(REG_STAT, 32'h2);
    csr_rd(REG_STAT, 32'h1, "rx_evt_cleared");

    // Second write while busy is dropped
    csr_wr(REG_RXTX, 32'h3C);
    csr_wr(REG_RXTX, 32'hF0);
    cnt = 0;
    while (uart_tx !== 1'b0 && cnt < 200) begin
      cyc();
      cnt++;
    end
    check("tx_start_seen", 32'(uart_tx), 32'd0);
    wait_n(BIT4 / 2);
    check("tx_start_mid", 32'(uart_tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      wait_n(BIT4);
      line_b[i] = uart_tx;
    end
    e.tag = "tx_line_first_byte";
    e.val = 32'h3C;
    sb_q.push_back(e);
    e = sb_q.pop_front();
    check(e.tag, 32'(line_b), e.val);
    wait_n(BIT4);
    check("tx_stop_bit", 32'(uart_tx), 32'd1);
    extra = 1'b0;
    for (int i = 0; i < 20 * BIT4; i++) begin
      cyc();
      if (uart_tx === 1'b0) extra = 1'b1;
    end
    check("no_second_frame", 32'(extra), 32'd0);
    csr_rd(REG_STAT, 32'h5, "stat_tx_evt_only");

    // Interrupt source selection
    csr_wr(REG_CTRL, 32'h1);
    check("irq_rx_int_tx_evt", 32'(irq), 32'd0);
    csr_wr(REG_CTRL, 32'h2);
    check("irq_tx_int_tx_evt", 32'(irq), 32'd1);
    csr_wr(REG_STAT, 32'h4);
    check("irq_tx_cleared", 32'(irq), 32'd0);
    csr_wr(REG_CTRL, 32'h0);

    // Reset in the middle of a frame
    csr_wr(REG_RXTX, 32'h00);
    wait_n(5 * BIT4);
    check("midframe_line_low", 32'(uart_tx), 32'd0);
    sys_rst = 1'b1;
    cyc();
    check("reset_line_high", 32'(uart_tx), 32'd1);
    check("reset_csr_do", csr_do, 32'd0);
    sys_rst = 1'b0;
    csr_rd(REG_DIVISOR, 32'd43, "divisor_restored");
    csr_rd(REG_STAT, 32'h1, "stat_after_midframe_reset");
    wait_n(3 * BIT4);
    csr_rd(REG_STAT, 32'h1, "no_pending_event_later");
    check("line_idle_after_reset", 32'(uart_tx), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_csr.md
UART_CSR -- requirements
Module: uart_csr

Interface
REQ-001 SHALL have parameter csr_addr, default 4'h0, meaning the 4-bit CSR bank select matched against csr_a[13:10].
REQ-002 SHALL have parameter clk_freq, default 100000000, meaning the sys_clk frequency in Hz.
REQ-003 SHALL have parameter baud, default 115200, meaning the line rate in bit/s.
REQ-004 SHALL have parameter break_en_default, default 1'b0, meaning the reset value of DEBUG.BREAK_EN.
REQ-005 SHALL have one clock; reset is synchronous and active-high: sys_clk input 1, the rising-edge clock.
REQ-006 SHALL have sys_rst input 1, the synchronous active-high reset.
REQ-007 SHALL have csr_a input 14, the CSR address: [13:10] is the bank, [2:0] is the register.
REQ-008 SHALL have csr_we input 1, the CSR write strobe (single cycle).
REQ-009 SHALL have csr_di input 32, the CSR write data.
REQ-010 SHALL have csr_do output 32, the registered CSR read data.
REQ-011 SHALL have irq output 1, the level interrupt.
REQ-012 SHALL have uart_rx input 1, the asynchronous serial input (idle high).
REQ-013 SHALL have uart_tx output 1, the serial output (idle high).
REQ-014 SHALL have break output 1, a one-cycle pulse on a detected line break.

Function
REQ-015 SHALL decode the bank as selected when csr_a[13:10]==csr_addr; register map: 0 RXTX, 1 DIVISOR, 2 STAT, 3 CTRL, 4 DEBUG; other offsets read 0 and ignore writes.
REQ-016 SHALL register csr_do one cycle after the address is presented, and drive 0 when the bank is not selected.
REQ-017 SHALL implement DIVISOR as 16 bits, reset to clk_freq/(16*baud) truncated (80 MHz at 115200 gives 43), writable from csr_di[15:0]; one bit time is 16*DIVISOR cycles.
REQ-018 SHALL use 8N1 framing, LSB first, with 16x oversampling; the receiver synchronizes uart_rx through two flops, validates the start bit at mid-bit and samples data at mid-bit.
REQ-019 SHALL, on a write to RXTX when STAT.THRE=1, load csr_di[7:0], clear THRE the next cycle and start transmission; a write while THRE=0 SHALL be ignored.
REQ-020 SHALL, at the end of the stop bit, set THRE and TX_EVT.
REQ-021 SHALL, on a valid stop bit (1), latch the byte into the RX holding register and set RX_EVT; reading RXTX returns {24'b0, rx_byte}.
REQ-022 SHALL provide STAT with bit0 THRE (read-only), bit1 RX_EVT and bit2 TX_EVT; writing 1 to an event bit clears it, and if a set and a clear occur in the same cycle the set wins.
REQ-023 SHALL provide CTRL with bit0 RX_INT, bit1 TX_INT and bit2 THRU, all read/write.
REQ-024 SHALL compute irq as (RX_EVT & RX_INT) | (TX_EVT & TX_INT), registered.
REQ-025 SHALL, when THRU=1, drive uart_tx = synchronized uart_rx; the transmitter keeps running internally.
REQ-026 SHALL provide DEBUG with bit0 BREAK_EN, read/write; when a frame has all-zero data and stop=0 and BREAK_EN=1, break pulses for one cycle, with no RX_EVT; if BREAK_EN=0 the frame is discarded.
REQ-027 SHALL resynchronize to a new start bit only after the line returns high after a framing error.

Reset
REQ-028 SHALL, on sys_rst, set: csr_do=0, irq=0, break=0, uart_tx=1, THRE=1, RX_EVT=TX_EVT=0, CTRL=0, DIVISOR to its default, BREAK_EN=break_en_default, and both FSMs to idle.
REQ-029 SHALL, on a reset mid-frame, abort transmission immediately, return the line high, and leave no pending event.

Structure
REQ-030 SHALL place the register offsets, STAT/CTRL/DEBUG bit positions and the default-divisor function in a shared package uart_csr_pkg.
REQ-031 SHALL use one sub-module, uart_transceiver (baud tick, RX FSM IDLE/START/DATA/STOP, TX FSM IDLE/START/DATA/STOP); the CSR logic stays in uart_csr.

Verification
REQ-032 SHALL verify: after reset, read DIVISOR -> 43 (clk_freq=80e6, baud=115200), read STAT -> 0x1.
REQ-033 SHALL verify: with uart_tx looped to uart_rx, write RXTX=0x55 -> THRE=0 for about 10 bit times, then STAT=0x7 and RXTX reads 0x55.
REQ-034 SHALL verify: CTRL=0x3, event pending -> irq=1; write STAT=0x6 -> irq=0 on the following cycle.
REQ-035 SHALL verify: drive uart_rx low for 12 bit times with BREAK_EN=1 -> one break pulse, RX_EVT stays 0.
REQ-036 SHALL verify: CTRL=0x4, toggle uart_rx -> uart_tx follows 2-3 cycles later.
REQ-037 SHALL verify: a second RXTX write while THRE=0 -> only the first byte appears on the line.
